// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_engine
//  Description : Copies a block of words from data memory into instruction
//                memory, one word at a time (READ -> CAPT -> WRITE per word).
//                The request is range-checked before any memory access, and
//                a rejected request produces a one-cycle err pulse.
//
//  Ports
//    clk          in   1   clock, rising-edge
//    rst          in   1   asynchronous active-high reset
//    start        in   1   copy request, sampled only while idle
//    src_addr     in  12   first data-memory word to read
//    dst_addr     in  12   first instruction-memory word to write
//    len          in  11   word count (0..1024)
//    data_addr    out 12   data-port address
//    rd_data_en   out  1   data-port read enable
//    data         in  32   data-port read data (valid cycle after rd_data_en)
//    instr_addr   out 12   instruction-port address
//    wr_instr_en  out  1   instruction-port write enable
//    wrt_instr    out 32   instruction write data
//    busy         out  1   high whenever not idle
//    done         out  1   one-cycle pulse: copy completed
//    err          out  1   one-cycle pulse: request rejected
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_copy_engine #(
    parameter logic [11:0] DATA_BASE = 12'h400,
    parameter logic [11:0] INSTR_TOP = 12'h3FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] src_addr,
    input  logic [11:0] dst_addr,
    input  logic [10:0] len,
    output logic [11:0] data_addr,
    output logic        rd_data_en,
    input  logic [31:0] data,
    output logic [11:0] instr_addr,
    output logic        wr_instr_en,
    output logic [31:0] wrt_instr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CHECK = 3'd1;
    localparam logic [2:0] c_READ  = 3'd2;
    localparam logic [2:0] c_CAPT  = 3'd3;
    localparam logic [2:0] c_WRITE = 3'd4;
    localparam logic [2:0] c_FIN   = 3'd5;

    logic [2:0]  state_q,       state_d;
    logic [11:0] src_ptr_q,     src_ptr_d;
    logic [11:0] dst_ptr_q,     dst_ptr_d;
    logic [10:0] cnt_q,         cnt_d;
    logic [11:0] data_addr_q,   data_addr_d;
    logic [11:0] instr_addr_q,  instr_addr_d;
    logic [31:0] wrt_instr_q,   wrt_instr_d;
    logic        rd_data_en_q,  rd_data_en_d;
    logic        wr_instr_en_q, wr_instr_en_d;
    logic        busy_q,        busy_d;
    logic        done_q,        done_d;
    logic        err_q,         err_d;

    // End addresses carried at 13 bits so an overrun past 12'hFFF is visible
    // instead of wrapping back to low memory.
    logic [12:0] w_src_end;
    logic [12:0] w_dst_end;

    assign w_src_end = {1'b0, src_ptr_q} + {2'b00, cnt_q} - 13'd1;
    assign w_dst_end = {1'b0, dst_ptr_q} + {2'b00, cnt_q} - 13'd1;

    always_comb begin
        state_d       = state_q;
        src_ptr_d     = src_ptr_q;
        dst_ptr_d     = dst_ptr_q;
        cnt_d         = cnt_q;
        wrt_instr_d   = wrt_instr_q;
        err_d         = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (start) begin
                    src_ptr_d = src_addr;
                    dst_ptr_d = dst_addr;
                    cnt_d     = len;
                    state_d   = c_CHECK;
                end
            end
            c_CHECK: begin
                if (cnt_q == 11'd0) begin
                    state_d = c_FIN;
                end else if ((src_ptr_q < DATA_BASE) ||
                             (w_src_end > 13'h0FFF) ||
                             (w_dst_end > {1'b0, INSTR_TOP})) begin
                    err_d   = 1'b1;
                    state_d = c_IDLE;
                end else begin
                    state_d = c_READ;
                end
            end
            c_READ: begin
                state_d = c_CAPT;
            end
            c_CAPT: begin
                // Read data is valid in this cycle, one cycle after the read.
                wrt_instr_d = data;
                state_d     = c_WRITE;
            end
            c_WRITE: begin
                src_ptr_d = src_ptr_q + 12'd1;
                dst_ptr_d = dst_ptr_q + 12'd1;
                cnt_d     = cnt_q - 11'd1;
                state_d   = (cnt_q == 11'd1) ? c_FIN : c_READ;
            end
            c_FIN: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // Outputs are registered: they are derived from the state being
        // entered so they line up with that state's cycle.
        rd_data_en_d  = (state_d == c_READ);
        wr_instr_en_d = (state_d == c_WRITE);
        done_d        = (state_d == c_FIN);
        busy_d        = (state_d != c_IDLE);
        data_addr_d   = (state_d == c_READ)  ? src_ptr_d : data_addr_q;
        instr_addr_d  = (state_d == c_WRITE) ? dst_ptr_d : instr_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= c_IDLE;
            src_ptr_q     <= 12'd0;
            dst_ptr_q     <= 12'd0;
            cnt_q         <= 11'd0;
            data_addr_q   <= 12'd0;
            instr_addr_q  <= 12'd0;
            wrt_instr_q   <= 32'd0;
            rd_data_en_q  <= 1'b0;
            wr_instr_en_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_ptr_q     <= src_ptr_d;
            dst_ptr_q     <= dst_ptr_d;
            cnt_q         <= cnt_d;
            data_addr_q   <= data_addr_d;
            instr_addr_q  <= instr_addr_d;
            wrt_instr_q   <= wrt_instr_d;
            rd_data_en_q  <= rd_data_en_d;
            wr_instr_en_q <= wr_instr_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign data_addr   = data_addr_q;
    assign rd_data_en  = rd_data_en_q;
    assign instr_addr  = instr_addr_q;
    assign wr_instr_en = wr_instr_en_q;
    assign wrt_instr   = wrt_instr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter DATA_BASE, default 12'h400, lowest legal data-memory word address.
REQ-002 Parameter INSTR_TOP, default 12'h3FF, highest legal instruction-memory word address.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  copy request; sampled only in IDLE.
REQ-006 src_addr  input  12  first data-memory word to read.
REQ-007 dst_addr  input  12  first instruction-memory word to write.
REQ-008 len  input  11  word count, 0..1024.
REQ-009 data_addr  output  12  data-port address, driven to Mem_control.
REQ-010 rd_data_en  output  1  data-port read enable.
REQ-011 data  input  32  data-port read data, valid the cycle after rd_data_en.
REQ-012 instr_addr  output  12  instruction-port address.
REQ-013 wr_instr_en  output  1  instruction-port write enable.
REQ-014 wrt_instr  output  32  instruction write data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse: copy completed.
REQ-017 err  output  1  one-cycle pulse: request rejected.

Function
REQ-018 FSM states: IDLE, CHECK, READ, CAPT, WRITE, FIN; encoding is free.
REQ-019 IDLE: start=1 latches src_addr, dst_addr and len, then moves to CHECK; start=0 stays in IDLE.
REQ-020 CHECK computes src_end=src+len-1 and dst_end=dst+len-1 at 13-bit width, so no wrap is possible.
REQ-021 CHECK: if len=0, go to FIN with no memory access.
REQ-022 CHECK: src<DATA_BASE, src_end>12'hFFF, or dst_end>INSTR_TOP -> err pulse next cycle, return to IDLE, no memory access.
REQ-023 CHECK: otherwise go to READ.
REQ-024 READ: rd_data_en=1, data_addr=current src pointer, for exactly one cycle; next state CAPT.
REQ-025 CAPT: register data into wrt_instr; all enables 0; next state WRITE.
REQ-026 WRITE: wr_instr_en=1, instr_addr=current dst pointer, for exactly one cycle.
REQ-027 WRITE: increment both pointers and decrement the remaining count.
REQ-028 WRITE: if remaining count was 1, go to FIN; else go to READ.
REQ-029 FIN: done=1 for one cycle, then return to IDLE.
REQ-030 Timing: start accepted at edge N -> first rd_data_en in cycle N+2; copy of L words asserts done in cycle N+2+3L.
REQ-031 rd_data_en and wr_instr_en are never high in the same cycle; each is a registered output.
REQ-032 start while busy is ignored and not queued; inputs changing while busy have no effect.
REQ-033 Outside READ, data_addr holds its last value; outside WRITE, instr_addr and wrt_instr hold their last values.
REQ-034 done and err never assert together.

Reset
REQ-035 rst=1 forces IDLE asynchronously and clears busy, done, err, rd_data_en and wr_instr_en.
REQ-036 rst=1 also clears data_addr, instr_addr, wrt_instr, the pointers and the count to 0.
REQ-037 Reset mid-copy aborts the copy with no further enable pulse and no done; words already written stay written.
REQ-038 The first start after rst deasserts is honoured normally.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- src=12'h400, dst=12'h000, len=4, data memory holding A0..A3 -> instr 0..3 = A0..A3; reads at 400..403; done in cycle N+14; busy high N+1..N+14.
- len=0 -> done in cycle N+2; no rd_data_en or wr_instr_en; err stays 0.
- src=12'h3FF -> err pulse in cycle N+2; no memory enables.
- dst=12'h3FE, len=4 -> err pulse in cycle N+2; no memory enables.
- src=12'hFFC, len=4 -> accepted; last read at FFF; no wrap to 000.
- rst asserted in CAPT of word 2 (len=4) -> enables drop immediately; only word 1 written; no done.
- start pulsed while busy -> ignored; the original copy completes unchanged.
